sd_card_cmd_responder: RTL and testbench
========================================

# sd_card_cmd_responder

Card-side command responder: a synthesizable SD card model that answers the host command sequences issued by the controller's state-check and init blocks. Accepts decoded host commands (index, 32-bit argument, CRC status) from a command receiver. Tracks the SD card state (IDLE/READY/IDENT/STBY/TRAN). Builds the R1/R1b/R3/R6 48-bit response with CRC7 and hands it to a response transmitter. Drives DAT0 busy after R1b. Used as the card model in system benches and FPGA loopback.

## Interface
- RCA, 16'h1234, relative card address published by CMD3.
- NCR_CYCLES, 2, idle cycles between CRC done and Resp_Send_En (min 2).
- BUSY_CYCLES, 16, DAT0-low cycles after an R1b response.
- Reset and clock (already decided): reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- Cmd_Valid  in  1  decoded command available; held until Cmd_Ack.
- Cmd_ID  in  6  command index.
- Cmd_Arg  in  32  command argument, Cmd_Arg[31:16] = RCA field.
- Cmd_Crc_Err  in  1  CRC7 of received command bad, qualified by Cmd_Valid.
- Cmd_Ack  out  1  one-cycle accept pulse.
- Resp_Data  out  48  response frame, stable while Resp_Send_En.
- Resp_Send_En  out  1  request to transmitter, held until Resp_Send_Complite.
- Resp_Send_Complite  in  1  transmitter finished frame.
- Dat0_Level  out  1  1 = ready, 0 = busy.
- Card_State  out  4  current state, encoding IDLE=0 READY=1 IDENT=2 STBY=3 TRAN=4.

## Operation
- Reset values: Card_State=IDLE, Cmd_Ack=0, Resp_Send_En=0, Resp_Data=0, Dat0_Level=1, APP_CMD/ILLEGAL/CRC_ERR flags=0.
- Responder FSM: S_WAIT → S_DECODE → S_CRC → S_NCR → S_SEND → S_BUSY (R1b only) → S_WAIT.
- S_WAIT: Cmd_Valid=1 → S_DECODE.
- S_DECODE: pulse Cmd_Ack, capture the pre-command card state, apply the transition, load frame bits [47:8], select the next state.
- Cmd_Crc_Err=1: set CRC_ERR, no state change, no response → S_WAIT.
- CMD0: → IDLE; clear all flags; no response.
- CMD55: set APP_CMD (valid only for the next command); R1.
- ACMD41 (CMD41 with APP_CMD set), in IDLE: → READY; R3.
- CMD2, in READY: → IDENT. R2 is not modelled; a 48-bit frame is emitted with index 63 and status 0.
- CMD3, in IDENT: → STBY; R6.
- CMD7, in STBY with arg RCA==RCA: → TRAN; R1b.
- CMD7, in STBY with other RCA: no change, no response.
- CMD7, in TRAN with other RCA: → STBY, no response.
- CMD7, in TRAN with own RCA: no change; R1b.
- CMD13 with arg RCA==RCA, in STBY/TRAN: R1. Other RCA: no response.
- Any other index/state pair: set ILLEGAL, no change, no response.
- R1/R1b frame:
  - [47:46]=00, [45:40]=Cmd_ID, [39:8]=card status, [7:1]=CRC7, [0]=1.
  - Status bits: 23 CRC_ERR, 22 ILLEGAL, 12:9 pre-command state (frame [20:17]), 8 READY_FOR_DATA = (state==TRAN), 5 APP_CMD.
- R6 frame: [39:24]=RCA; [23:8] = {CRC_ERR, ILLEGAL, 1'b0, 13-bit status[12:0]}; CRC7 as R1.
- R3 frame: [45:40]=6'h3F; [39:8]=32'hC0FF_8000 (busy bit set, CCS, 2.7–3.6 V); [7:1]=7'h7F (no CRC).
- CRC_ERR/ILLEGAL clear after being reported in any response.
- APP_CMD clears on any accepted command other than CMD55.
- S_CRC: serial CRC7 (x^7+x^3+1) over frame [47:8], MSB first, one bit per clk, 40 cycles. R3 skips S_CRC.
- S_SEND: Resp_Send_En=1 until Resp_Send_Complite, deassert the same edge. R1b → S_BUSY, else → S_WAIT.
- S_BUSY: Dat0_Level=0 for BUSY_CYCLES clocks → S_WAIT.

## Timing
- Cmd_Ack is asserted 1 cycle after Cmd_Valid is sampled in S_WAIT.
- Cmd_Valid outside S_WAIT is not acked; upstream holds it.
- Card_State updates on the S_DECODE edge.
- Resp_Send_En rises at: S_DECODE + 40 (CRC) + NCR_CYCLES cycles. R3 path: S_DECODE + NCR_CYCLES.
- Resp_Data changes only in S_DECODE and the S_CRC final cycle.
- Back-to-back commands: the next accept is no earlier than 1 cycle after return to S_WAIT.
- rst mid-S_SEND/S_BUSY: all outputs return to reset values on the next edge; the pending frame is dropped.

## Structure
- Package sd_card_pkg holds: state encodings (shared with host-side check logic), command index constants, status bit positions, R3 OCR constant.
- Sub-module sd_crc7_serial: clk, rst, start, bit in/valid, 7-bit crc out; reused by host-side CRC logic.

## Test plan
- Reset → Card_State=0, Dat0_Level=1, Resp_Send_En=0; CMD0 → Cmd_Ack, no Resp_Send_En within 100 cycles.
- CMD55 then CMD41 → R3 frame [45:40]=3F, [39:8]=C0FF8000, [7:1]=7F; Card_State=1. Then CMD2, then CMD3 → R6 [39:24]=1234, state 3.
- In STBY, CMD13 arg 0x12340000 → R1 [20:17]=3, CRC7 equals reference model. CMD7 0x12340000 → R1b [20:17]=3; Card_State=4; Dat0_Level low exactly 16 cycles after Resp_Send_Complite.
- In TRAN, CMD7 arg 0 → no response, Card_State=3. CMD13 arg 0x55550000 → no response.
- Cmd_Crc_Err=1 on CMD13, then valid CMD13 → second R1 has frame bit 31=1. The following CMD13 has bit 31=0.
- Reset asserted while Resp_Send_En=1 → Resp_Send_En=0 and Card_State=0 next cycle. CMD7 in IDLE → no response; next accepted response has ILLEGAL (bit 30)=1.

Source files
------------

// File: rtl/sd_card_pkg.sv
// Shared SD card definitions: card states, command indices, status bit positions, R3 OCR.
package sd_card_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_READY = 4'd1,
    ST_IDENT = 4'd2,
    ST_STBY  = 4'd3,
    ST_TRAN  = 4'd4
  } card_state_t;

  typedef enum logic [2:0] {
    RSP_NONE,
    RSP_R1,
    RSP_R1B,
    RSP_R2,
    RSP_R3,
    RSP_R6
  } resp_kind_t;

  localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
  localparam logic [5:0] CMD_ALL_SEND_CID    = 6'd2;
  localparam logic [5:0] CMD_SEND_RCA        = 6'd3;
  localparam logic [5:0] CMD_SELECT          = 6'd7;
  localparam logic [5:0] CMD_SEND_STATUS     = 6'd13;
  localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
  localparam logic [5:0] CMD_APP             = 6'd55;
  localparam logic [5:0] RSP_IDX_NO_CMD      = 6'h3F;

  localparam int unsigned STAT_CRC_ERR    = 23;
  localparam int unsigned STAT_ILLEGAL    = 22;
  localparam int unsigned STAT_STATE_LSB  = 9;
  localparam int unsigned STAT_READY_DATA = 8;
  localparam int unsigned STAT_APP_CMD    = 5;

  localparam logic [31:0] R3_OCR     = 32'hC0FF_8000;
  localparam logic [6:0]  R3_NO_CRC  = 7'h7F;
  localparam int unsigned CRC_CYCLES = 40;

endpackage

// File: rtl/sd_crc7_serial.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first, one bit per clock; start clears the register.
module sd_crc7_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [6:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[6];

  // LFSR update
  always_ff @(posedge clk) begin
    if (rst || start) crc <= '0;
    else if (bit_valid) crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD command responder: tracks card state and answers host commands with CRC'd frames.
module sd_card_cmd_responder
  import sd_card_pkg::*;
#(
  parameter logic [15:0] RCA         = 16'h1234,
  parameter int unsigned NCR_CYCLES  = 2,
  parameter int unsigned BUSY_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Cmd_Valid,
  input  logic [5:0]  Cmd_ID,
  input  logic [31:0] Cmd_Arg,
  input  logic        Cmd_Crc_Err,
  output logic        Cmd_Ack,
  output logic [47:0] Resp_Data,
  output logic        Resp_Send_En,
  input  logic        Resp_Send_Complite,
  output logic        Dat0_Level,
  output logic [3:0]  Card_State
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {S_WAIT, S_DECODE, S_CRC, S_NCR, S_SEND, S_BUSY} fsm_t;

  fsm_t             state, state_d;
  card_state_t      card, card_d;
  resp_kind_t       kind, kind_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             crc_flag, crc_flag_d, ill_flag, ill_flag_d, app_flag, app_flag_d;
  logic             ack_d, send_d, dat0_d;
  logic [47:0]      data_d;
  logic [31:0]      status_c;
  logic             rca_match;
  logic [6:0]       crc;
  logic             crc_bit;
  logic             arg_unused;

  // Low argument half carries stuff bits only
  assign arg_unused = ^Cmd_Arg[15:0];
  assign rca_match  = (Cmd_Arg[31:16] == RCA);

  // Bit 47 is always 0 and leaves a cleared CRC at 0, so feeding starts at bit 46
  assign crc_bit = Resp_Data[6'(46 - int'(cnt))];

  sd_crc7_serial u_crc (
    .clk       (clk),
    .rst       (rst),
    .start     (state == S_DECODE),
    .bit_in    (crc_bit),
    .bit_valid ((state == S_CRC) && (cnt < CNT_W'(CRC_CYCLES - 1))),
    .crc       (crc)
  );

  // Card status word as reported in R1/R6, using the pre-command card state
  always_comb begin
    status_c = '0;
    status_c[STAT_CRC_ERR] = crc_flag;
    status_c[STAT_ILLEGAL] = ill_flag;
    status_c[STAT_STATE_LSB +: 4] = card;
    status_c[STAT_READY_DATA] = (card == ST_TRAN);
    status_c[STAT_APP_CMD] = (Cmd_ID == CMD_APP);
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_WAIT;
      card         <= ST_IDLE;
      kind         <= RSP_NONE;
      cnt          <= '0;
      crc_flag     <= 1'b0;
      ill_flag     <= 1'b0;
      app_flag     <= 1'b0;
      Cmd_Ack      <= 1'b0;
      Resp_Send_En <= 1'b0;
      Dat0_Level   <= 1'b1;
      Resp_Data    <= '0;
    end else begin
      state        <= state_d;
      card         <= card_d;
      kind         <= kind_d;
      cnt          <= cnt_d;
      crc_flag     <= crc_flag_d;
      ill_flag     <= ill_flag_d;
      app_flag     <= app_flag_d;
      Cmd_Ack      <= ack_d;
      Resp_Send_En <= send_d;
      Dat0_Level   <= dat0_d;
      Resp_Data    <= data_d;
    end
  end

  assign Card_State = card;

  // Next-state, command decode and frame assembly
  always_comb begin
    state_d    = state;
    card_d     = card;
    kind_d     = kind;
    cnt_d      = cnt;
    crc_flag_d = crc_flag;
    ill_flag_d = ill_flag;
    app_flag_d = app_flag;
    ack_d      = 1'b0;
    send_d     = Resp_Send_En;
    dat0_d     = Dat0_Level;
    data_d     = Resp_Data;

    case (state)
      S_WAIT: begin
        if (Cmd_Valid) begin
          ack_d   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        kind_d = RSP_NONE;
        cnt_d  = '0;
        if (Cmd_Crc_Err) begin
          crc_flag_d = 1'b1;
        end else begin
          app_flag_d = (Cmd_ID == CMD_APP);
          case (Cmd_ID)
            CMD_GO_IDLE: begin
              card_d     = ST_IDLE;
              crc_flag_d = 1'b0;
              ill_flag_d = 1'b0;
            end
            CMD_APP: kind_d = RSP_R1;
            CMD_SD_SEND_OP_COND: begin
              if (app_flag && card == ST_IDLE) begin
                card_d = ST_READY;
                kind_d = RSP_R3;
              end else ill_flag_d = 1'b1;
            end
            CMD_ALL_SEND_CID: begin
              if (card == ST_READY) begin
                card_d = ST_IDENT;
                kind_d = RSP_R2;
              end else ill_flag_d = 1'b1;
            end
            CMD_SEND_RCA: begin
              if (card == ST_IDENT) begin
                card_d = ST_STBY;
                kind_d = RSP_R6;
              end else ill_flag_d = 1'b1;
            end
            CMD_SELECT: begin
              if (card == ST_STBY) begin
                if (rca_match) begin
                  card_d = ST_TRAN;
                  kind_d = RSP_R1B;
                end
              end else if (card == ST_TRAN) begin
                if (rca_match) kind_d = RSP_R1B;
                else card_d = ST_STBY;
              end else ill_flag_d = 1'b1;
            end
            CMD_SEND_STATUS: begin
              if (card == ST_STBY || card == ST_TRAN) begin
                if (rca_match) kind_d = RSP_R1;
              end else ill_flag_d = 1'b1;
            end
            default: ill_flag_d = 1'b1;
          endcase
        end

        case (kind_d)
          RSP_R1, RSP_R1B: begin
            data_d     = {2'b00, Cmd_ID, status_c, 7'd0, 1'b1};
            crc_flag_d = 1'b0;
            ill_flag_d = 1'b0;
          end
          RSP_R2: data_d = {2'b00, RSP_IDX_NO_CMD, 32'd0, 7'd0, 1'b1};
          RSP_R3: data_d = {2'b00, RSP_IDX_NO_CMD, R3_OCR, R3_NO_CRC, 1'b1};
          RSP_R6: begin
            data_d     = {2'b00, Cmd_ID, RCA, crc_flag, ill_flag, 1'b0, status_c[12:0], 7'd0, 1'b1};
            crc_flag_d = 1'b0;
            ill_flag_d = 1'b0;
          end
          default: ;
        endcase

        case (kind_d)
          RSP_NONE: state_d = S_WAIT;
          RSP_R3:   state_d = S_NCR;
          default:  state_d = S_CRC;
        endcase
      end

      S_CRC: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_W'(CRC_CYCLES - 1)) begin
          data_d[7:1] = crc;
          cnt_d       = '0;
          state_d     = S_NCR;
        end
      end

      S_NCR: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_W'(NCR_CYCLES - 1)) begin
          cnt_d   = '0;
          send_d  = 1'b1;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (Resp_Send_Complite) begin
          send_d = 1'b0;
          if (kind == RSP_R1B) begin
            dat0_d  = 1'b0;
            state_d = S_BUSY;
          end else state_d = S_WAIT;
        end
      end

      S_BUSY: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_W'(BUSY_CYCLES - 1)) begin
          cnt_d   = '0;
          dat0_d  = 1'b1;
          state_d = S_WAIT;
        end
      end

      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench for sd_card_cmd_responder: init sequence, select/status, error flags, reset mid-send.
module tb_sd_card_cmd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        Cmd_Valid;
  logic [5:0]  Cmd_ID;
  logic [31:0] Cmd_Arg;
  logic        Cmd_Crc_Err;
  logic        Cmd_Ack;
  logic [47:0] Resp_Data;
  logic        Resp_Send_En;
  logic        Resp_Send_Complite;
  logic        Dat0_Level;
  logic [3:0]  Card_State;

  int n_tests = 0;
  int n_fail  = 0;

  sd_card_cmd_responder dut (
    .clk                (clk),
    .rst                (rst),
    .Cmd_Valid          (Cmd_Valid),
    .Cmd_ID             (Cmd_ID),
    .Cmd_Arg            (Cmd_Arg),
    .Cmd_Crc_Err        (Cmd_Crc_Err),
    .Cmd_Ack            (Cmd_Ack),
    .Resp_Data          (Resp_Data),
    .Resp_Send_En       (Resp_Send_En),
    .Resp_Send_Complite (Resp_Send_Complite),
    .Dat0_Level         (Dat0_Level),
    .Card_State         (Card_State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference CRC7, x^7+x^3+1, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] frame(input logic [5:0] idx, input logic [31:0] body);
    logic [39:0] h;
    h = {2'b00, idx, body};
    return {h, crc7(h), 1'b1};
  endfunction

  // Present a command, check the one-cycle ack, then release it
  task automatic issue(input string tag, input logic [5:0] id, input logic [31:0] arg,
                       input logic crc_err);
    int ack_at;
    ack_at = 99;
    @(negedge clk);
    Cmd_Valid = 1'b1; Cmd_ID = id; Cmd_Arg = arg; Cmd_Crc_Err = crc_err;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Cmd_Ack) begin
        ack_at = i;
        break;
      end
    end
    chk({tag, " ack latency"}, 48'(ack_at), 48'd0);
    @(negedge clk);
    chk({tag, " ack pulse"}, 48'(Cmd_Ack), 48'd0);
    Cmd_Valid = 1'b0; Cmd_Crc_Err = 1'b0;
  endtask

  // Wait for Resp_Send_En; lat is measured in cycles from the decode edge
  task automatic get_resp(input int max, output bit got, output int lat, output logic [47:0] f);
    got = 1'b0; lat = 0; f = '0;
    for (int k = 2; k < max; k++) begin
      @(negedge clk);
      if (Resp_Send_En) begin
        got = 1'b1; lat = k - 1; f = Resp_Data;
        break;
      end
    end
  endtask

  task automatic complete(input string tag);
    Resp_Send_Complite = 1'b1;
    @(negedge clk);
    Resp_Send_Complite = 1'b0;
    chk({tag, " send_en drop"}, 48'(Resp_Send_En), 48'd0);
  endtask

  task automatic expect_resp(input string tag, input logic [5:0] id, input logic [31:0] arg,
                             input logic [47:0] exp_f, input int exp_lat, input logic [3:0] exp_st);
    bit got; int lat; logic [47:0] f;
    issue(tag, id, arg, 1'b0);
    get_resp(100, got, lat, f);
    chk({tag, " resp"}, 48'(got), 48'd1);
    chk({tag, " latency"}, 48'(lat), 48'(exp_lat));
    chk({tag, " frame"}, f, exp_f);
    chk({tag, " card_state"}, 48'(Card_State), 48'(exp_st));
    complete(tag);
  endtask

  task automatic expect_none(input string tag, input logic [5:0] id, input logic [31:0] arg,
                             input logic crc_err, input int cycles, input logic [3:0] exp_st);
    bit got; int lat; logic [47:0] f;
    issue(tag, id, arg, crc_err);
    get_resp(cycles, got, lat, f);
    chk({tag, " no resp"}, 48'(got), 48'd0);
    chk({tag, " card_state"}, 48'(Card_State), 48'(exp_st));
  endtask

  initial begin
    int low;
    bit got; int lat; logic [47:0] f;

    rst = 1'b1; Cmd_Valid = 1'b0; Cmd_ID = '0; Cmd_Arg = '0; Cmd_Crc_Err = 1'b0;
    Resp_Send_Complite = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst card_state", 48'(Card_State), 48'd0);
    chk("rst dat0", 48'(Dat0_Level), 48'd1);
    chk("rst send_en", 48'(Resp_Send_En), 48'd0);
    chk("rst ack", 48'(Cmd_Ack), 48'd0);
    chk("rst resp_data", Resp_Data, 48'd0);

    expect_none("cmd0", 6'd0, 32'd0, 1'b0, 100, 4'd0);

    // Init sequence
    expect_resp("cmd55", 6'd55, 32'd0, frame(6'd55, 32'h0000_0020), 42, 4'd0);
    expect_resp("acmd41", 6'd41, 32'h40FF_8000,
                {2'b00, 6'h3F, 32'hC0FF_8000, 7'h7F, 1'b1}, 2, 4'd1);
    expect_resp("cmd2", 6'd2, 32'd0, frame(6'h3F, 32'd0), 42, 4'd2);
    expect_resp("cmd3", 6'd3, 32'd0, frame(6'd3, 32'h1234_0400), 42, 4'd3);

    // Standby: status, then select
    expect_resp("cmd13 stby", 6'd13, 32'h1234_0000, frame(6'd13, 32'h0000_0600), 42, 4'd3);
    expect_resp("cmd7 sel", 6'd7, 32'h1234_0000, frame(6'd7, 32'h0000_0600), 42, 4'd4);
    low = Dat0_Level ? 0 : 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Dat0_Level) break;
      low++;
    end
    chk("r1b busy cycles", 48'(low), 48'd16);

    // Transfer state: status shows TRAN and READY_FOR_DATA
    expect_resp("cmd13 tran", 6'd13, 32'h1234_0000, frame(6'd13, 32'h0000_0900), 42, 4'd4);
    expect_none("cmd7 desel", 6'd7, 32'd0, 1'b0, 60, 4'd3);
    expect_none("cmd13 other rca", 6'd13, 32'h5555_0000, 1'b0, 60, 4'd3);

    // CRC error reported once, then cleared
    expect_none("cmd13 crc err", 6'd13, 32'h1234_0000, 1'b1, 60, 4'd3);
    expect_resp("cmd13 crc rpt", 6'd13, 32'h1234_0000, frame(6'd13, 32'h0080_0600), 42, 4'd3);
    expect_resp("cmd13 crc clr", 6'd13, 32'h1234_0000, frame(6'd13, 32'h0000_0600), 42, 4'd3);

    // Reset while a response is pending
    issue("cmd13 rst", 6'd13, 32'h1234_0000, 1'b0);
    get_resp(100, got, lat, f);
    chk("rst mid send resp", 48'(got), 48'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid send send_en", 48'(Resp_Send_En), 48'd0);
    chk("rst mid send card_state", 48'(Card_State), 48'd0);
    chk("rst mid send dat0", 48'(Dat0_Level), 48'd1);

    // Illegal command flagged in the next response
    expect_none("cmd7 idle", 6'd7, 32'h1234_0000, 1'b0, 60, 4'd0);
    expect_resp("cmd55 ill", 6'd55, 32'd0, frame(6'd55, 32'h0040_0020), 42, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
